// File: rtl/rca_pipe_pkg.sv
// Shared definitions for the pipelined ripple-carry adder/subtractor.
// Defaults, chunk-width helper and the default-sized stage-valid type.
package rca_pipe_pkg;

  localparam int RCA_DEF_WIDTH  = 16;
  localparam int RCA_DEF_STAGES = 4;

  typedef logic [RCA_DEF_STAGES-1:0] stage_valid_t;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/rca_pipe_addsub_chunk.sv
// Combinational CW-bit ripple adder built from full-adder cells (module rca_chunk).
// Also exports the carry into its top bit so the final stage can form signed overflow.
module rca_chunk
  import rca_pipe_pkg::*;
#(
  parameter int CW = chunk_width(RCA_DEF_WIDTH, RCA_DEF_STAGES)
) (
  input  logic [CW-1:0] x,
  input  logic [CW-1:0] y,
  input  logic          ci,
  output logic [CW-1:0] sum,
  output logic          co,
  output logic          c_msb_in
);

  logic [CW:0] w_c;

  assign w_c[0] = ci;

  for (genvar gi = 0; gi < CW; gi++) begin : g_fa
    assign sum[gi]    = x[gi] ^ y[gi] ^ w_c[gi];
    assign w_c[gi+1]  = (x[gi] & y[gi]) | (w_c[gi] & (x[gi] ^ y[gi]));
  end

  assign co       = w_c[CW];
  assign c_msb_in = w_c[CW-1];

endmodule

// File: rtl/rca_pipe_addsub.sv
// Pipelined ripple-carry adder/subtractor: one CW-bit chunk per stage, carry registered between stages.
// Optional macro RCA_PIPE_SATURATE_EN replaces an overflowing result with the signed saturation value.
module rca_pipe_addsub
  import rca_pipe_pkg::*;
#(
  parameter int WIDTH  = RCA_DEF_WIDTH,
  parameter int STAGES = RCA_DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             ov
);

  localparam int CW = chunk_width(WIDTH, STAGES);

  logic              w_adv;
  logic [WIDTH-1:0]  w_b_eff;
  logic              w_cin_eff;
  logic              w_ov_next;

  // r_as: completed sum chunks in the low bits, not-yet-added bits of a above them
  logic [STAGES-1:0] r_vld;
  logic [STAGES-1:0] r_cy;
  logic [WIDTH-1:0]  r_as [STAGES];
  logic [WIDTH-1:0]  r_bs [STAGES];
  logic              r_ov;

  logic [WIDTH-1:0]  w_src_as  [STAGES];
  logic [WIDTH-1:0]  w_src_bs  [STAGES];
  logic [WIDTH-1:0]  w_as_next [STAGES];
  logic [STAGES-1:0] w_src_ci;
  logic [STAGES-1:0] w_src_vld;
  logic [STAGES-1:0] w_co;
  logic              w_cmsb [STAGES];

  assign w_b_eff   = sub ? ~b : b;
  assign w_cin_eff = sub | cin;
  assign w_adv     = ~r_vld[STAGES-1] | out_ready;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic [CW-1:0]    w_sum;
    logic [WIDTH-1:0] w_merged;

    if (gi == 0) begin : g_first
      assign w_src_as[gi]  = a;
      assign w_src_bs[gi]  = w_b_eff;
      assign w_src_ci[gi]  = w_cin_eff;
      assign w_src_vld[gi] = in_valid;
    end else begin : g_next
      assign w_src_as[gi]  = r_as[gi-1];
      assign w_src_bs[gi]  = r_bs[gi-1];
      assign w_src_ci[gi]  = r_cy[gi-1];
      assign w_src_vld[gi] = r_vld[gi-1];
    end

    rca_chunk #(.CW(CW)) u_chunk (
      .x        (w_src_as[gi][gi*CW +: CW]),
      .y        (w_src_bs[gi][gi*CW +: CW]),
      .ci       (w_src_ci[gi]),
      .sum      (w_sum),
      .co       (w_co[gi]),
      .c_msb_in (w_cmsb[gi])
    );

    always_comb begin
      w_merged                = w_src_as[gi];
      w_merged[gi*CW +: CW]   = w_sum;
    end

    if (gi == STAGES - 1) begin : g_last
      assign w_ov_next = w_cmsb[gi] ^ w_co[gi];
`ifdef RCA_PIPE_SATURATE_EN
      logic [WIDTH-1:0] w_sat;
      // Bit WIDTH-1 of the source is still the untouched MSB of a at this point
      always_comb begin
        w_sat = w_merged;
        if (w_ov_next) begin
          w_sat = w_src_as[gi][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                        : {1'b0, {(WIDTH-1){1'b1}}};
        end
      end
      assign w_as_next[gi] = w_sat;
`else
      assign w_as_next[gi] = w_merged;
`endif
    end else begin : g_mid
      assign w_as_next[gi] = w_merged;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      r_cy  <= '0;
      r_ov  <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        r_as[k] <= '0;
        r_bs[k] <= '0;
      end
    end else if (w_adv) begin
      r_vld <= w_src_vld;
      r_cy  <= w_co;
      r_ov  <= w_ov_next;
      for (int k = 0; k < STAGES; k++) begin
        r_as[k] <= w_as_next[k];
        r_bs[k] <= w_src_bs[k];
      end
    end
  end

  assign in_ready  = w_adv;
  assign out_valid = r_vld[STAGES-1];
  assign s         = r_as[STAGES-1];
  assign c         = r_cy[STAGES-1];
  assign ov        = r_ov;

endmodule
